// File: rtl/ldm_stm_addr_sequencer.sv
// LDM/STM address sequencer: turns a register list and base address into one
// register/address beat per clock, followed by an optional Rn writeback cycle.
module ldm_stm_addr_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [NUM_REGS-1:0]   reg_list_in,
    input  logic [ADDR_W-1:0]     base_addr_in,
    input  logic [1:0]            mode_in,
    input  logic                  wback_in,
    input  logic [TAG_W-1:0]      instr_tag_in,
    input  logic                  flush_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [ADDR_W-1:0]     addr_to_mem_out,
    output logic                  last_out,
    output logic [TAG_W-1:0]      instr_tag_out,
    output logic [ADDR_W-1:0]     rn_data_out,
    output logic                  rn_wr_en_out,
    output logic                  busy_out
);

    localparam int unsigned CNT_W = REG_ADDR_W + 1;
    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_e;

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   list_q, list_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     wb_val_q, wb_val_d;
    logic                  wback_q, wback_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic                  last_q, last_d;
    logic                  rn_wr_en_q, rn_wr_en_d;
    logic                  busy_q, busy_d;

    logic [CNT_W-1:0]      n_regs;
    logic [ADDR_W-1:0]     four_n;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [REG_ADDR_W-1:0] lowest_set(input logic [NUM_REGS-1:0] v);
        logic [REG_ADDR_W-1:0] idx;
        logic                  found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (v[i] && !found) begin
                idx   = REG_ADDR_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign n_regs = popcount(reg_list_in);
    assign four_n = ADDR_W'(n_regs) << 2;

    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        addr_d   = addr_q;
        wb_val_d = wb_val_q;
        wback_d  = wback_q;
        tag_d    = tag_q;

        if (flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        list_d  = reg_list_in;
                        wback_d = wback_in;
                        tag_d   = instr_tag_in;
                        // Every mode issues ascending addresses; only the start point differs.
                        case (mode_in)
                            2'b00:   addr_d = base_addr_in;
                            2'b01:   addr_d = base_addr_in + WORD;
                            2'b10:   addr_d = base_addr_in - four_n + WORD;
                            default: addr_d = base_addr_in - four_n;
                        endcase
                        wb_val_d = mode_in[1] ? (base_addr_in - four_n) : (base_addr_in + four_n);
                        state_d  = (n_regs != '0) ? S_ISSUE : S_WB;
                    end
                end
                S_ISSUE: begin
                    if (ready_in) begin
                        list_d = list_q & (list_q - NUM_REGS'(1));
                        addr_d = addr_q + WORD;
                        if (last_q) begin
                            state_d = S_WB;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are precomputed from next state so they leave straight from flops.
        valid_d    = (state_d == S_ISSUE);
        busy_d     = (state_d != S_IDLE);
        rn_wr_en_d = (state_d == S_WB) && wback_d;
        reg_addr_d = lowest_set(list_d);
        last_d     = valid_d && (list_d != '0) && ((list_d & (list_d - NUM_REGS'(1))) == '0);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            wback_q    <= 1'b0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            reg_addr_q <= '0;
            last_q     <= 1'b0;
            rn_wr_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            wb_val_q   <= wb_val_d;
            wback_q    <= wback_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            reg_addr_q <= reg_addr_d;
            last_q     <= last_d;
            rn_wr_en_q <= rn_wr_en_d;
            busy_q     <= busy_d;
        end
    end

    assign valid_out       = valid_q;
    assign reg_addr_out    = reg_addr_q;
    assign addr_to_mem_out = addr_q;
    assign last_out        = last_q;
    assign instr_tag_out   = tag_q;
    assign rn_data_out     = wb_val_q;
    assign rn_wr_en_out    = rn_wr_en_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_ldm_stm_addr_sequencer.sv
// Directed bench for ldm_stm_addr_sequencer: table of complete transfers plus
// hand-written stall, flush, reset and busy-start sequences.
module tb_ldm_stm_addr_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [15:0] reg_list_in;
    logic [31:0] base_addr_in;
    logic [1:0]  mode_in;
    logic        wback_in;
    logic [3:0]  instr_tag_in;
    logic        flush_in;
    logic        ready_in;
    logic        valid_out;
    logic [3:0]  reg_addr_out;
    logic [31:0] addr_to_mem_out;
    logic        last_out;
    logic [3:0]  instr_tag_out;
    logic [31:0] rn_data_out;
    logic        rn_wr_en_out;
    logic        busy_out;

    ldm_stm_addr_sequencer #(
        .ADDR_W(32), .NUM_REGS(16), .REG_ADDR_W(4), .TAG_W(4)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
        .reg_list_in(reg_list_in), .base_addr_in(base_addr_in), .mode_in(mode_in),
        .wback_in(wback_in), .instr_tag_in(instr_tag_in), .flush_in(flush_in),
        .ready_in(ready_in), .valid_out(valid_out), .reg_addr_out(reg_addr_out),
        .addr_to_mem_out(addr_to_mem_out), .last_out(last_out),
        .instr_tag_out(instr_tag_out), .rn_data_out(rn_data_out),
        .rn_wr_en_out(rn_wr_en_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] list;
        logic [31:0] base;
        logic        wback;
        logic [3:0]  tag;
        int          n;
        logic [31:0] addr0;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_beat(input string name, input logic [3:0] r, input logic [31:0] a,
                              input logic lst);
        chk({name, ".valid"}, 32'(valid_out), 32'd1);
        chk({name, ".reg"},   32'(reg_addr_out), 32'(r));
        chk({name, ".addr"},  addr_to_mem_out, a);
        chk({name, ".last"},  32'(last_out), 32'(lst));
        chk({name, ".busy"},  32'(busy_out), 32'd1);
        chk({name, ".wr"},    32'(rn_wr_en_out), 32'd0);
    endtask

    task automatic check_idle(input string name);
        chk({name, ".valid"}, 32'(valid_out), 32'd0);
        chk({name, ".busy"},  32'(busy_out), 32'd0);
        chk({name, ".wr"},    32'(rn_wr_en_out), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".valid"}, 32'(valid_out), 32'd0);
        chk({name, ".reg"},   32'(reg_addr_out), 32'd0);
        chk({name, ".addr"},  addr_to_mem_out, 32'd0);
        chk({name, ".last"},  32'(last_out), 32'd0);
        chk({name, ".tag"},   32'(instr_tag_out), 32'd0);
        chk({name, ".data"},  rn_data_out, 32'd0);
        chk({name, ".wr"},    32'(rn_wr_en_out), 32'd0);
        chk({name, ".busy"},  32'(busy_out), 32'd0);
    endtask

    task automatic start_op(input logic [1:0] m, input logic [15:0] l, input logic [31:0] b,
                            input logic w, input logic [3:0] t);
        mode_in = m; reg_list_in = l; base_addr_in = b; wback_in = w; instr_tag_in = t;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    initial begin
        logic [15:0] lst;
        logic [3:0]  idx;

        //              mode   list      base          wb    tag   n   addr0         writeback
        vecs[0] = '{2'b00, 16'h0013, 32'h0000_1000, 1'b1, 4'h3, 3,  32'h0000_1000, 32'h0000_100C};
        vecs[1] = '{2'b11, 16'h8001, 32'h0000_2000, 1'b1, 4'h5, 2,  32'h0000_1FF8, 32'h0000_1FF8};
        vecs[2] = '{2'b01, 16'h0006, 32'h0000_1000, 1'b0, 4'h9, 2,  32'h0000_1004, 32'h0000_1008};
        vecs[3] = '{2'b10, 16'h0000, 32'h0000_0040, 1'b1, 4'hA, 0,  32'h0000_0000, 32'h0000_0040};
        vecs[4] = '{2'b00, 16'h0003, 32'hFFFF_FFFC, 1'b1, 4'h1, 2,  32'hFFFF_FFFC, 32'h0000_0004};
        vecs[5] = '{2'b10, 16'h00F0, 32'h0000_0100, 1'b1, 4'hC, 4,  32'h0000_00F4, 32'h0000_00F0};
        vecs[6] = '{2'b01, 16'hFFFF, 32'h0000_0000, 1'b1, 4'hF, 16, 32'h0000_0004, 32'h0000_0040};
        vecs[7] = '{2'b11, 16'h0001, 32'h0000_0010, 1'b0, 4'h6, 1,  32'h0000_000C, 32'h0000_000C};

        reset_in = 1'b1; start_in = 1'b0; reg_list_in = '0; base_addr_in = '0; mode_in = '0;
        wback_in = 1'b0; instr_tag_in = '0; flush_in = 1'b0; ready_in = 1'b1;
        #2 reset_in = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) tick();
        @(negedge clk_in);
        reset_in = 1'b1;
        tick();
        check_all_zero("post_reset");

        for (int v = 0; v < 8; v++) begin
            start_op(vecs[v].mode, vecs[v].list, vecs[v].base, vecs[v].wback, vecs[v].tag);
            lst = vecs[v].list;
            for (int k = 0; k < vecs[v].n; k++) begin
                idx = '0;
                for (int i = 15; i >= 0; i--) if (lst[i]) idx = 4'(i);
                check_beat($sformatf("v%0d.b%0d", v, k), idx, vecs[v].addr0 + 32'(4 * k),
                           k == vecs[v].n - 1);
                chk($sformatf("v%0d.b%0d.tag", v, k), 32'(instr_tag_out), 32'(vecs[v].tag));
                lst = lst & (lst - 16'd1);
                tick();
            end
            chk($sformatf("v%0d.wb.valid", v), 32'(valid_out), 32'd0);
            chk($sformatf("v%0d.wb.busy", v), 32'(busy_out), 32'd1);
            chk($sformatf("v%0d.wb.wr", v), 32'(rn_wr_en_out), 32'(vecs[v].wback));
            chk($sformatf("v%0d.wb.data", v), rn_data_out, vecs[v].wb);
            tick();
            check_idle($sformatf("v%0d.done", v));
        end

        // Stall: first beat held for three ready-low cycles.
        start_op(2'b01, 16'h0006, 32'h0000_1000, 1'b1, 4'h2);
        ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_beat($sformatf("stall.c%0d", c), 4'd1, 32'h0000_1004, 1'b0);
            tick();
        end
        ready_in = 1'b1;
        check_beat("stall.rel", 4'd1, 32'h0000_1004, 1'b0);
        tick();
        check_beat("stall.b1", 4'd2, 32'h0000_1008, 1'b1);
        tick();
        chk("stall.wb.wr", 32'(rn_wr_en_out), 32'd1);
        chk("stall.wb.data", rn_data_out, 32'h0000_1008);
        tick();
        check_idle("stall.done");

        // Flush during second of four beats.
        start_op(2'b00, 16'h000F, 32'h0000_0300, 1'b1, 4'h4);
        check_beat("flush.b0", 4'd0, 32'h0000_0300, 1'b0);
        tick();
        check_beat("flush.b1", 4'd1, 32'h0000_0304, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_idle("flush.next");
        for (int c = 0; c < 4; c++) begin
            tick();
            check_idle($sformatf("flush.after%0d", c));
        end

        // Flush wins over start in IDLE.
        flush_in = 1'b1;
        start_op(2'b00, 16'h0001, 32'h0000_0800, 1'b1, 4'h7);
        flush_in = 1'b0;
        check_idle("flush_start");

        // Asynchronous reset during second of four beats.
        start_op(2'b00, 16'h000F, 32'h0000_0300, 1'b1, 4'h4);
        tick();
        check_beat("rst.b1", 4'd1, 32'h0000_0304, 1'b0);
        #2 reset_in = 1'b0;
        #1 check_all_zero("rst.async");
        @(negedge clk_in);
        reset_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle($sformatf("rst.after%0d", c));
        end
        start_op(2'b00, 16'h0001, 32'h0000_0700, 1'b1, 4'h8);
        check_beat("rst.restart", 4'd0, 32'h0000_0700, 1'b1);
        tick();
        chk("rst.restart.wr", 32'(rn_wr_en_out), 32'd1);
        chk("rst.restart.data", rn_data_out, 32'h0000_0704);
        tick();
        check_idle("rst.restart.done");

        // start_in held high while busy is ignored.
        start_op(2'b00, 16'h0003, 32'h0000_0500, 1'b1, 4'hB);
        start_in = 1'b1; base_addr_in = 32'h0000_0900; reg_list_in = 16'h00FF;
        check_beat("busy.b0", 4'd0, 32'h0000_0500, 1'b0);
        tick();
        check_beat("busy.b1", 4'd1, 32'h0000_0504, 1'b1);
        tick();
        start_in = 1'b0;
        chk("busy.wb.data", rn_data_out, 32'h0000_0508);
        chk("busy.wb.tag", 32'(instr_tag_out), 32'hB);
        tick();
        check_idle("busy.done");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
